// File: rtl/bg_ctrl.sv
// Background-removal sequencer: PE sum handshake, serial divide-by-NUM_PIXELS, bg handshake.
// Define BG_CTRL_TIMEOUT_EN to enable the PE response watchdog and the ERR state.
module bg_ctrl #(
  parameter  int NUM_PIXELS     = 1,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int SW             = 8*NUM_PIXELS+1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic          Start_Sum,
  output logic          Start_BgRemoval,
  output logic          Ack,
  input  logic          Qsd,
  input  logic          Qbgd,
  input  logic [SW-1:0] red_sum,
  input  logic [SW-1:0] green_sum,
  input  logic [SW-1:0] blue_sum,
  output logic [8:0]    red_exp,
  output logic [8:0]    green_exp,
  output logic [8:0]    blue_exp
);
  localparam int RW  = $clog2(NUM_PIXELS+1) + 1;
  localparam int RMW = RW - 1;
  localparam int CW  = $clog2(SW+1);

  typedef enum logic [9:0] {
    IDLE      = 10'b00_0000_0001,
    SUM_START = 10'b00_0000_0010,
    SUM_WAIT  = 10'b00_0000_0100,
    SUM_ACK   = 10'b00_0000_1000,
    DIVIDE    = 10'b00_0001_0000,
    BG_START  = 10'b00_0010_0000,
    BG_WAIT   = 10'b00_0100_0000,
    BG_ACK    = 10'b00_1000_0000,
    DONE      = 10'b01_0000_0000,
    ERR       = 10'b10_0000_0000
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0][SW-1:0]     sum_q, dvd_q, qf;
  logic [2:0][SW-2:0]     quo_q;
  logic [2:0][RMW-1:0]    rem_q, rem_nx;
  logic [2:0][8:0]        exp_q, exp_nx;
  logic [CW-1:0]          cnt_q;
  logic                   last, wd_hit;

  assign last = (state_q == DIVIDE) && (cnt_q == CW'(SW-1));

  // One restoring step per channel: shift in the next dividend bit, subtract if it fits.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [RW-1:0] r;
    logic          qb;
    assign r         = {rem_q[c], dvd_q[c][SW-1]};
    assign qb        = r >= RW'(NUM_PIXELS);
    assign rem_nx[c] = qb ? RMW'(r - RW'(NUM_PIXELS)) : r[RMW-1:0];
    assign qf[c]     = {quo_q[c], qb};
    assign exp_nx[c] = (|qf[c][SW-1:8]) ? 9'd255 : {1'b0, qf[c][7:0]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (Go) state_d = SUM_START;
      SUM_START: state_d = SUM_WAIT;
      SUM_WAIT:  if (Qsd) state_d = SUM_ACK;
      SUM_ACK:   if (!Qsd) state_d = DIVIDE;
      DIVIDE:    if (last) state_d = BG_START;
      BG_START:  state_d = BG_WAIT;
      BG_WAIT:   if (Qbgd) state_d = BG_ACK;
      BG_ACK:    if (!Qbgd) state_d = DONE;
      DONE:      state_d = IDLE;
      ERR:       state_d = ERR;
      default:   state_d = IDLE;
    endcase
    if (wd_hit) state_d = ERR;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sum_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SUM_WAIT && Qsd) begin
        sum_q[0] <= red_sum;
        sum_q[1] <= green_sum;
        sum_q[2] <= blue_sum;
      end
      if (state_q == SUM_ACK && state_d == DIVIDE) begin
        dvd_q <= sum_q;
        quo_q <= '0;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (state_q == DIVIDE) begin
        for (int c = 0; c < 3; c++) begin
          dvd_q[c] <= {dvd_q[c][SW-2:0], 1'b0};
          quo_q[c] <= qf[c][SW-2:0];
          rem_q[c] <= rem_nx[c];
        end
        cnt_q <= cnt_q + CW'(1);
        if (last) exp_q <= exp_nx;
      end
    end
  end

`ifdef BG_CTRL_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        wait_st;
  assign wait_st = (state_q == SUM_WAIT) || (state_q == SUM_ACK) ||
                   (state_q == BG_WAIT)  || (state_q == BG_ACK);
  assign wd_hit  = wait_st && ((wd_q + 16'd1) == 16'(TIMEOUT_CYCLES));

  // Counter restarts on every state change so each wait/ack phase gets a full budget.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) wd_d = '0;
    else if (wait_st)       wd_d = wd_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign Err = (state_q == ERR);
`else
  logic unused_tmo;
  assign unused_tmo = |16'(TIMEOUT_CYCLES);
  assign wd_hit     = 1'b0;
  assign Err        = 1'b0;
`endif

  assign Busy            = (state_q != IDLE);
  assign Done            = (state_q == DONE);
  assign Start_Sum       = (state_q == SUM_START);
  assign Start_BgRemoval = (state_q == BG_START);
  assign Ack             = (state_q == SUM_ACK) || (state_q == BG_ACK);
  assign red_exp         = exp_q[0];
  assign green_exp       = exp_q[1];
  assign blue_exp        = exp_q[2];
endmodule

// File: tb/tb_bg_ctrl.sv
// Bench for bg_ctrl: two instances (NUM_PIXELS 1 and 4), reactive PE model, exp scoreboard.
module tb_bg_ctrl;
  typedef struct packed {logic [8:0] r; logic [8:0] g; logic [8:0] b;} exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  go, busy, done, err, ss, sb, ack, bg_hang;
  logic [1:0]  qsd = '0, qbgd = '0;
  logic [8:0]  rs1, gs1, bs1, re1, ge1, be1, re4, ge4, be4;
  logic [32:0] rs4, gs4, bs4;
  exp_t        sb_q[$], obs_q[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  bg_ctrl #(.NUM_PIXELS(1), .TIMEOUT_CYCLES(8)) dut1 (
    .Clk(clk), .Reset(rst), .Go(go[0]), .Busy(busy[0]), .Done(done[0]), .Err(err[0]),
    .Start_Sum(ss[0]), .Start_BgRemoval(sb[0]), .Ack(ack[0]), .Qsd(qsd[0]), .Qbgd(qbgd[0]),
    .red_sum(rs1), .green_sum(gs1), .blue_sum(bs1),
    .red_exp(re1), .green_exp(ge1), .blue_exp(be1));

  bg_ctrl #(.NUM_PIXELS(4), .TIMEOUT_CYCLES(8)) dut4 (
    .Clk(clk), .Reset(rst), .Go(go[1]), .Busy(busy[1]), .Done(done[1]), .Err(err[1]),
    .Start_Sum(ss[1]), .Start_BgRemoval(sb[1]), .Ack(ack[1]), .Qsd(qsd[1]), .Qbgd(qbgd[1]),
    .red_sum(rs4), .green_sum(gs4), .blue_sum(bs4),
    .red_exp(re4), .green_exp(ge4), .blue_exp(be4));

  // PE model: answers a start pulse in one cycle, drops status once Ack is seen.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        qsd[d]  = 1'b0;
        qbgd[d] = 1'b0;
      end else begin
        if (ss[d]) qsd[d] = 1'b1;
        else if (qsd[d] && ack[d]) qsd[d] = 1'b0;
        if (sb[d] && !bg_hang[d]) qbgd[d] = 1'b1;
        else if (qbgd[d] && ack[d]) qbgd[d] = 1'b0;
      end
    end
  end

  // mode 0: single Go pulse; 1: extra pulse at cycle extra_at; 2: Go held until second Done.
  task automatic run_pass(input int d, input logic [32:0] r, g, b, input int mode, input int extra_at,
                          output int lat, output int lat2, output int af, output int sbk,
                          output int nd, output int nsb, output int idl);
    logic pa;
    exp_t o;
    lat = 0; lat2 = 0; af = 0; sbk = 0; nd = 0; nsb = 0; idl = 0; pa = 1'b0;
    if (d == 0) begin rs1 = r[8:0]; gs1 = g[8:0]; bs1 = b[8:0]; end
    else begin rs4 = r; gs4 = g; bs4 = b; end
    go[d] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (mode != 2) go[d] = (mode == 1 && k == extra_at);
      if (pa && !ack[d] && af == 0) begin
        af = k;
        if (mode != 2) begin
          if (d == 0) begin rs1 = 9'($urandom); gs1 = 9'($urandom); bs1 = 9'($urandom); end
          else begin rs4 = 33'({$urandom, $urandom}); gs4 = 33'($urandom); bs4 = 33'($urandom); end
        end
      end
      pa = ack[d];
      if (sb[d]) begin nsb++; if (sbk == 0) sbk = k; end
      if (done[d]) begin
        o = (d == 0) ? {re1, ge1, be1} : {re4, ge4, be4};
        obs_q.push_back(o);
        nd++;
        if (nd == 1) lat = k; else if (nd == 2) lat2 = k;
        if (mode == 2 && nd == 2) go[d] = 1'b0;
      end
      if (mode == 2 && nd == 1 && !busy[d]) idl++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, ss, sb, ack} !== 12'h0) begin
      errors++; $display("FAIL reset_ctrl: got %h want 000", {busy, done, err, ss, sb, ack});
    end
    checks++;
    if ({re1, ge1, be1, re4, ge4, be4} !== 54'h0) begin
      errors++; $display("FAIL reset_exp: got %h want 0", {re1, ge1, be1, re4, ge4, be4});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, lat2, af, sbk, nd, nsb, idl;
    exp_t o, e;
    sb_q.push_back({9'd61, 9'd133, 9'd198});
    run_pass(0, 33'd61, 33'd133, 33'd198, 0, 0, lat, lat2, af, sbk, nd, nsb, idl);
    checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d want 16", lat); end
    checks++; if (sbk - af !== 9) begin errors++; $display("FAIL basic_ack_to_bgstart: got %0d want 9", sbk - af); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    checks++; if (nsb !== 1) begin errors++; $display("FAIL basic_bgstart_count: got %0d want 1", nsb); end
    e = sb_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL basic_exp: got no Done want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL basic_exp: got %h want %h", o, e); end
    end
  endtask

  task automatic test_divide4;
    int lat, lat2, af, sbk, nd, nsb, idl;
    exp_t o, e;
    sb_q.push_back({9'd61, 9'd133, 9'd198});
    run_pass(1, 33'd244, 33'd532, 33'd795, 0, 0, lat, lat2, af, sbk, nd, nsb, idl);
    checks++; if (sbk - af !== 33) begin errors++; $display("FAIL div4_divide_len: got %0d want 33", sbk - af); end
    checks++; if (lat !== 40) begin errors++; $display("FAIL div4_latency: got %0d want 40", lat); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL div4_done_count: got %0d want 1", nd); end
    e = sb_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL div4_exp: got no Done want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL div4_exp: got %h want %h", o, e); end
    end
  endtask

  task automatic test_saturate;
    int lat, lat2, af, sbk, nd, nsb, idl;
    exp_t o, e;
    sb_q.push_back({9'd255, 9'd255, 9'd0});
    run_pass(0, 33'd300, 33'd255, 33'd0, 0, 0, lat, lat2, af, sbk, nd, nsb, idl);
    e = sb_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL sat1_exp: got no Done want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL sat1_exp: got %h want %h", o, e); end
    end
    sb_q.push_back({9'd255, 9'd254, 9'd255});
    run_pass(1, 33'h1_FFFF_FFFF, 33'd1019, 33'd1024, 0, 0, lat, lat2, af, sbk, nd, nsb, idl);
    e = sb_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL sat4_exp: got no Done want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL sat4_exp: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_divide;
    int nsb, nd, nbusy;
    rs1 = 9'd61; gs1 = 9'd133; bs1 = 9'd198;
    go[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      go[0] = 1'b0;
    end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL rstdiv_busy_before: got %b want 1", busy[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy[0], done[0], err[0], ss[0], sb[0], ack[0]} !== 6'h0) begin
      errors++; $display("FAIL rstdiv_ctrl: got %b want 000000", {busy[0], done[0], err[0], ss[0], sb[0], ack[0]});
    end
    checks++;
    if ({re1, ge1, be1} !== 27'h0) begin errors++; $display("FAIL rstdiv_exp: got %h want 0", {re1, ge1, be1}); end
    nsb = 0; nd = 0; nbusy = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sb[0]) nsb++;
      if (done[0]) nd++;
      if (busy[0]) nbusy++;
    end
    checks++;
    if (nsb + nd + nbusy !== 0) begin
      errors++; $display("FAIL rstdiv_quiet: got bgstart=%0d done=%0d busy=%0d want 0", nsb, nd, nbusy);
    end
  endtask

  task automatic test_go_ignored;
    int lat, lat2, af, sbk, nd, nsb, idl;
    exp_t o, e;
    sb_q.push_back({9'd5, 9'd6, 9'd7});
    run_pass(0, 33'd5, 33'd6, 33'd7, 1, 14, lat, lat2, af, sbk, nd, nsb, idl);
    checks++; if (nd !== 1) begin errors++; $display("FAIL goign_done_count: got %0d want 1", nd); end
    checks++; if (nsb !== 1) begin errors++; $display("FAIL goign_bgstart_count: got %0d want 1", nsb); end
    checks++; if (lat !== 16) begin errors++; $display("FAIL goign_latency: got %0d want 16", lat); end
    e = sb_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL goign_exp: got no Done want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL goign_exp: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, lat2, af, sbk, nd, nsb, idl;
    exp_t o, e;
    sb_q.push_back({9'd10, 9'd20, 9'd30});
    sb_q.push_back({9'd10, 9'd20, 9'd30});
    run_pass(0, 33'd10, 33'd20, 33'd30, 2, 0, lat, lat2, af, sbk, nd, nsb, idl);
    checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    checks++; if (lat2 - lat !== 17) begin errors++; $display("FAIL b2b_spacing: got %0d want 17", lat2 - lat); end
    checks++; if (idl !== 1) begin errors++; $display("FAIL b2b_idle_cycles: got %0d want 1", idl); end
    for (int i = 0; i < 2; i++) begin
      e = sb_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_exp%0d: got no Done want %h", i, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_exp%0d: got %h want %h", i, o, e); end
      end
    end
  endtask

  task automatic test_timeout;
    int bgw, errk, nerr;
    bg_hang[0] = 1'b1;
    rs1 = 9'd1; gs1 = 9'd2; bs1 = 9'd3;
    bgw = 0; errk = 0; nerr = 0;
    go[0] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      go[0] = 1'b0;
      if (sb[0] && bgw == 0) bgw = k + 1;
      if (err[0]) begin nerr++; if (errk == 0) errk = k; end
    end
`ifdef BG_CTRL_TIMEOUT_EN
    checks++; if (errk - bgw !== 8) begin errors++; $display("FAIL tmo_err_delay: got %0d want 8", errk - bgw); end
    checks++; if (nerr !== 61 - errk) begin errors++; $display("FAIL tmo_err_held: got %0d want %0d", nerr, 61 - errk); end
    checks++;
    if ({err[0], ack[0], busy[0]} !== 3'b101) begin
      errors++; $display("FAIL tmo_err_state: got %b want 101", {err[0], ack[0], busy[0]});
    end
`else
    checks++; if (nerr !== 0) begin errors++; $display("FAIL tmo_err_never: got %0d want 0", nerr); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL tmo_busy_wait: got %b want 1", busy[0]); end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bg_hang[0] = 1'b0;
    checks++;
    if ({err[0], busy[0]} !== 2'b00) begin errors++; $display("FAIL tmo_after_reset: got %b want 00", {err[0], busy[0]}); end
  endtask

  initial begin
    rst = 1'b1; go = '0; bg_hang = '0;
    rs1 = '0; gs1 = '0; bs1 = '0; rs4 = '0; gs4 = '0; bs4 = '0;
    test_reset;
    test_basic;
    test_divide4;
    test_saturate;
    test_reset_divide;
    test_go_ignored;
    test_back_to_back;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bg_ctrl.md
BG_CTRL -- requirements
Module: bg_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 1; the number of pixels per processing element (PE), range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024; the PE response watchdog limit in cycles, range 2..65535.
REQ-003 SHALL define local width SW = 8*NUM_PIXELS+1, matching the PE sum buses.
REQ-004 SHALL have port Clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit; synchronous, active-high reset.
REQ-006 SHALL have port Go, input, 1 bit; requests one frame pass, sampled only in IDLE.
REQ-007 SHALL have port Busy, output, 1 bit; high in every state except IDLE.
REQ-008 SHALL have port Done, output, 1 bit; high in DONE.
REQ-009 SHALL have port Err, output, 1 bit; high in ERR.
REQ-010 SHALL have port Start_Sum, output, 1 bit; a one-cycle pulse to the PE.
REQ-011 SHALL have port Start_BgRemoval, output, 1 bit; a one-cycle pulse to the PE.
REQ-012 SHALL have port Ack, output, 1 bit; the acknowledge to the PE.
REQ-013 SHALL have ports Qsd and Qbgd, inputs, 1 bit each; the PE sum-done and bg-done status.
REQ-014 SHALL have ports red_sum, green_sum and blue_sum, inputs, SW bits each; the PE channel sums.
REQ-015 SHALL have ports red_exp, green_exp and blue_exp, outputs, 9 bits each; the expected background colour sent to the PE.

Function
REQ-016 SHALL implement the states IDLE, SUM_START, SUM_WAIT, SUM_ACK, DIVIDE, BG_START, BG_WAIT, BG_ACK, DONE and ERR, one-hot encoded.
REQ-017 SHALL take these transitions:
- IDLE to SUM_START when Go=1.
- SUM_START to SUM_WAIT unconditionally.
- SUM_WAIT to SUM_ACK when Qsd=1.
- SUM_ACK to DIVIDE when Qsd=0.
- DIVIDE to BG_START after exactly SW cycles.
- BG_START to BG_WAIT unconditionally.
- BG_WAIT to BG_ACK when Qbgd=1.
- BG_ACK to DONE when Qbgd=0.
- DONE to IDLE unconditionally after one cycle.
REQ-018 SHALL assert Start_Sum only in SUM_START and Start_BgRemoval only in BG_START, each for exactly one cycle.
REQ-019 SHALL assert Ack in SUM_ACK and BG_ACK, held until the matching Qsd or Qbgd is sampled low.
REQ-020 SHALL register all three sums in the cycle Qsd is sampled high in SUM_WAIT; later sum changes SHALL have no effect on the pass.
REQ-021 SHALL compute each exp value in DIVIDE as floor(sum/NUM_PIXELS) using a serial restoring divider, one quotient bit per cycle, with all three channels in parallel.
REQ-022 SHALL saturate any quotient above 255 to 255.
REQ-023 SHALL update red_exp, green_exp and blue_exp only on the final DIVIDE cycle, and SHALL hold them stable through BG_START, BG_WAIT, BG_ACK and DONE until the next DIVIDE completes.
REQ-024 SHALL ignore Go in every state other than IDLE; Go held high in DONE SHALL start a new pass one cycle after the return to IDLE.
REQ-025 SHALL treat Qsd outside SUM_WAIT/SUM_ACK, and Qbgd outside BG_WAIT/BG_ACK, as don't-care.
REQ-026 SHALL produce a minimum pass latency from Go to Done of SW+7 cycles when the PE responds in one cycle.

Reset
REQ-027 SHALL, when Reset=1 at a clock edge, enter IDLE and clear Busy, Done, Err, Start_Sum, Start_BgRemoval, Ack, the exp outputs, the sum registers, the divider registers and the watchdog counter to 0.
REQ-028 SHALL give Reset priority over all other inputs, including mid-DIVIDE and mid-handshake; no pulse SHALL be emitted in the cycle after Reset.

Configuration
REQ-029 SHALL, when BG_CTRL_TIMEOUT_EN is defined, run a 16-bit watchdog that clears on entry to SUM_WAIT, SUM_ACK, BG_WAIT and BG_ACK, increments on every cycle spent in those states, and forces a move to ERR when it reaches TIMEOUT_CYCLES.
REQ-030 SHALL, when BG_CTRL_TIMEOUT_EN is defined, hold ERR with Ack=0 until Reset.
REQ-031 SHALL, when BG_CTRL_TIMEOUT_EN is undefined, omit the watchdog, make ERR unreachable, tie Err to 0, and wait indefinitely for the PE.

Verification
REQ-032 SHALL check: NUM_PIXELS=1; Go pulse; PE returns Qsd with sums 61/133/198 -> exp=61/133/198; Start_BgRemoval occurs exactly 9 cycles after Ack drops; Done pulses once.
REQ-033 SHALL check: NUM_PIXELS=4; sums 244/532/795 -> exp=61/133/198 (floor); DIVIDE lasts 33 cycles.
REQ-034 SHALL check: NUM_PIXELS=1; red_sum=300 -> red_exp=255 (saturated).
REQ-035 SHALL check: Reset asserted on DIVIDE cycle 3 -> next cycle IDLE, all outputs 0, no Start_BgRemoval seen.
REQ-036 SHALL check: Go pulses during BG_WAIT -> ignored, exactly one Done; with Go held high -> back-to-back passes with one IDLE cycle between them.
REQ-037 SHALL check: with BG_CTRL_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, Qbgd never rises -> Err=1 exactly 8 cycles after BG_WAIT entry, held until Reset; without the macro -> Err stays 0 and Busy stays 1.
